instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Byte-stream program loader that sits directly upstream of the instruction memory. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Each word is written into instruction memory through the write port (address, data, write enable). Once the full image is written, the loader asserts `cpu_run`, which releases the processor core (PC, registers, data memory) from reset.

## Interface
- `ADDR_W`, default 9: instruction memory word-address width.
- `DEPTH`, default 512: maximum number of words. Must be ≤ 2^ADDR_W.
- `clk` input, 1: single system clock; everything is on the rising edge.
- `reset` input, 1: asynchronous, active-high reset.
- `in_valid` input, 1: a byte is offered on `in_data`.
- `in_data` input, 8: stream byte.
- `in_ready` output, 1: the loader will accept a byte. A byte transfers on a cycle where `in_valid && in_ready`.
- `restart` input, 1: synchronous pulse. Returns the loader from DONE or ERR to HDR0. Ignored in other states.
- `mem_we` output, 1: instruction memory write enable, one-cycle pulse per word.
- `mem_addr` output, ADDR_W: word address for the write.
- `mem_d` output, 32: word data for the write.
- `cpu_run` output, 1: high means the core runs. The core's reset is `reset | ~cpu_run`.
- `load_err` output, 1: high while in ERR.
- `words_loaded` output, ADDR_W+1: count of words written in the current load.

## Operation
- Frame format: count_hi, count_lo, then 4·N payload bytes, then (only with checksum enabled) one checksum byte.
  - N = {count_hi, count_lo} is a 16-bit word count.
- States: HDR0 → HDR1 → DATA → (CHK) → DONE; any state can go to ERR as listed below.
- HDR0: accept count_hi, then go to HDR1.
- HDR1: accept count_lo, then form N.
  - If N == 0 or N > DEPTH, go to ERR.
  - Otherwise clear the word address to 0 and go to DATA.
- DATA: bytes shift into a 32-bit assembly register; the first byte of a word lands in [31:24] and the last in [7:0].
  - On the 4th byte of a word, the assembled word and current address are registered into `mem_d` and `mem_addr`.
  - `mem_we` pulses for one cycle, then the address and `words_loaded` increment.
  - After word N-1 is accepted, go to CHK if checksum is enabled, else DONE.
- `in_ready` is 1 in HDR0, HDR1, DATA and CHK, and 0 in DONE and ERR. There are no back-pressure bubbles: a byte may be accepted on every cycle, including the `mem_we` cycle.
- DONE: `cpu_run` = 1. Further bytes are not accepted. `restart` sets `cpu_run` = 0 and goes to HDR0.
- ERR: `cpu_run` = 0 and `load_err` = 1. `restart` clears `load_err` and goes to HDR0.
- Reset mid-load: the loader returns to HDR0 immediately. Words already written stay in memory; there is no cleanup.
- `words_loaded` is cleared on entry to HDR0 (reset or `restart`). It is not cleared in HDR1.

## Timing
- Reset values: `in_ready` = 1 (state HDR0), `mem_we` = 0, `mem_addr` = 0, `mem_d` = 0, `cpu_run` = 0, `load_err` = 0, `words_loaded` = 0.
- If the 4th byte of a word is accepted in cycle T, `mem_we`, `mem_addr` and `mem_d` are valid in cycle T+1.
- If the last payload byte is accepted in cycle T and checksum is disabled:
  - DONE is entered at T+1, with `in_ready` = 0 at T+1.
  - `cpu_run` rises at T+2, strictly after the final `mem_we` (T+1).
- If the checksum byte is accepted in cycle T, `cpu_run` or `load_err` rises at T+1.
- A `restart` asserted in cycle T puts the loader in HDR0 at T+1, with `in_ready` = 1.
- The address never wraps, because N ≤ DEPTH is checked in HDR1.

## Configuration
- `LOADER_CHECKSUM_EN`
  - Defined:
    - The CHK state exists.
    - An 8-bit running XOR covers all payload bytes; header bytes are excluded.
    - The received checksum byte must equal that XOR: on a match go to DONE, on a mismatch go to ERR.
    - Words have already been written to memory either way.
  - Undefined: there is no CHK state and no checksum byte; DATA goes straight to DONE.

## Test plan
- Reset then stream 00 02 / 24 08 00 05 / 00 00 00 0D:
  - `mem_we` pulses twice: addr 0 ← 0x24080005, addr 1 ← 0x0000000D.
  - `words_loaded` = 2.
  - `cpu_run` = 1 two cycles after the last byte.
- Header 00 00 → ERR: `load_err` = 1, `in_ready` = 0, no `mem_we`. Header 02 01 (N = 513) → ERR likewise.
- Full 512-word stream, `in_valid` held high back-to-back: 512 `mem_we` pulses, the last at addr 511, `words_loaded` = 512, no dropped bytes.
- Assert `reset` after 6 payload bytes, then send a fresh 1-word frame:
  - The word is written to addr 0.
  - `cpu_run` = 1.
  - `words_loaded` = 1.
- Checksum build, payload 11 22 33 44: checksum 44 → DONE; checksum 45 → ERR with `cpu_run` = 0. `restart` from ERR gives HDR0 and `load_err` = 0 the next cycle.
- `in_valid` toggling every other cycle during DATA: words are assembled correctly and `mem_we` pulses only after every 4th accepted byte.

Source files
------------

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - framed byte-stream loader that fills instruction memory and releases the core.
// Optional checksum byte after the payload is enabled by defining LOADER_CHECKSUM_EN.
module instr_mem_loader #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_d,
  output logic              cpu_run,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_HDR0 = 3'd0,
    S_HDR1 = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t            state, next_state;
  logic [7:0]        count_hi;
  logic [ADDR_W-1:0] last_idx;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        byte_cnt;
  logic [23:0]       asm_q;
  logic              accept;
  logic              last_byte;
  logic [15:0]       n_words;
  logic [15:0]       n_minus1;
  logic              n_bad;
  logic              run_next;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        chk;
`endif

  assign accept    = in_valid && in_ready;
  assign n_words   = {count_hi, in_data};
  assign n_minus1  = n_words - 16'd1;
  assign n_bad     = (n_words == 16'd0) || ({16'd0, n_words} > DEPTH);
  assign last_byte = (byte_cnt == 2'd3) && (addr == last_idx);
  assign load_err  = (state == S_ERR);

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    case (state)
      S_HDR0: begin
        in_ready = 1'b1;
        if (in_valid) next_state = S_HDR1;
      end
      S_HDR1: begin
        in_ready = 1'b1;
        if (in_valid) next_state = n_bad ? S_ERR : S_DATA;
      end
      S_DATA: begin
        in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        if (in_valid && last_byte) next_state = S_CHK;
`else
        if (in_valid && last_byte) next_state = S_DONE;
`endif
      end
      S_CHK: begin
`ifdef LOADER_CHECKSUM_EN
        in_ready = 1'b1;
        if (in_valid) next_state = (in_data == chk) ? S_DONE : S_ERR;
`else
        next_state = S_ERR;
`endif
      end
      S_DONE: if (restart) next_state = S_HDR0;
      S_ERR:  if (restart) next_state = S_HDR0;
      default: next_state = S_ERR;
    endcase
  end

  // Without a checksum, cpu_run waits one DONE cycle so it rises after the final mem_we.
  always_comb begin
    run_next = 1'b0;
    if (next_state == S_DONE) begin
`ifdef LOADER_CHECKSUM_EN
      run_next = (state == S_DONE) || (state == S_CHK);
`else
      run_next = (state == S_DONE);
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_HDR0;
      count_hi     <= 8'd0;
      last_idx     <= '0;
      addr         <= '0;
      byte_cnt     <= 2'd0;
      asm_q        <= 24'd0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_d        <= 32'd0;
      cpu_run      <= 1'b0;
      words_loaded <= '0;
    end else begin
      state   <= next_state;
      cpu_run <= run_next;
      mem_we  <= 1'b0;
      if (mem_we) words_loaded <= words_loaded + (ADDR_W+1)'(1);
      case (state)
        S_HDR0: if (accept) count_hi <= in_data;
        S_HDR1: if (accept) begin
          last_idx <= n_minus1[ADDR_W-1:0];
          addr     <= '0;
          byte_cnt <= 2'd0;
        end
        S_DATA: if (accept) begin
          asm_q    <= {asm_q[15:0], in_data};
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            mem_d    <= {asm_q, in_data};
            mem_addr <= addr;
            mem_we   <= 1'b1;
            addr     <= addr + ADDR_W'(1);
          end
        end
        S_DONE, S_ERR: if (restart) words_loaded <= '0;
        default: ;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR over payload bytes only; cleared as the header completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk <= 8'd0;
    end else if (state == S_HDR1) begin
      chk <= 8'd0;
    end else if (state == S_DATA && accept) begin
      chk <= chk ^ in_data;
    end
  end
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - directed self-checking bench for instr_mem_loader.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        restart = 1'b0;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_d;
  logic        cpu_run;
  logic        load_err;
  logic [9:0]  words_loaded;

  int tests = 0;
  int fails = 0;
  int we_count = 0;
  int we_base;
  int bad;
  logic [31:0] mem [0:511];

  instr_mem_loader #(.ADDR_W(9), .DEPTH(512)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .restart(restart), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_d(mem_d), .cpu_run(cpu_run), .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_d;
      we_count <= we_count + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  function automatic logic [7:0] pb(int w, int j);
    return 8'((w * 13 + j * 71) & 255);
  endfunction

  function automatic logic [31:0] pw(int w);
    return {pb(w, 0), pb(w, 1), pb(w, 2), pb(w, 3)};
  endfunction

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'hFFFF_FFFF;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_d", mem_d, 32'd0);
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic two-word frame.
    send(8'h00); send(8'h02);
    send(8'h24); send(8'h08); send(8'h00); send(8'h05);
    check("w0_we", 32'(mem_we), 32'd1);
    check("w0_addr", 32'(mem_addr), 32'd0);
    check("w0_data", mem_d, 32'h2408_0005);
    send(8'h00); send(8'h00); send(8'h00); send(8'h0D);
    check("w1_we", 32'(mem_we), 32'd1);
    check("w1_addr", 32'(mem_addr), 32'd1);
    check("w1_data", mem_d, 32'h0000_000D);
    check("t1_in_ready", 32'(in_ready), 32'd0);
    check("t1_cpu_run", 32'(cpu_run), 32'd0);
    idle();
    check("t2_cpu_run", 32'(cpu_run), 32'd1);
    check("t2_words", 32'(words_loaded), 32'd2);
    check("t2_we_count", 32'(we_count), 32'd2);
    check("mem0", mem[0], 32'h2408_0005);
    check("mem1", mem[1], 32'h0000_000D);

    // Restart from DONE, then bad headers.
    pulse_restart();
    check("rs_in_ready", 32'(in_ready), 32'd1);
    check("rs_cpu_run", 32'(cpu_run), 32'd0);
    check("rs_words", 32'(words_loaded), 32'd0);
    we_base = we_count;
    send(8'h00); send(8'h00);
    check("n0_err", 32'(load_err), 32'd1);
    check("n0_in_ready", 32'(in_ready), 32'd0);
    send(8'hAA);
    check("n0_no_we", 32'(we_count - we_base), 32'd0);
    pulse_restart();
    check("err_clr", 32'(load_err), 32'd0);
    send(8'h02); send(8'h01);
    check("n513_err", 32'(load_err), 32'd1);
    check("n513_cpu_run", 32'(cpu_run), 32'd0);
    pulse_restart();

    // Full 512-word image, back-to-back.
    we_base = we_count;
    in_valid = 1'b1;
    in_data = 8'h02;
    @(posedge clk); #1;
    in_data = 8'h00;
    @(posedge clk); #1;
    for (int w = 0; w < 512; w++) begin
      for (int j = 0; j < 4; j++) begin
        in_data = pb(w, j);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    check("full_last_we", 32'(mem_we), 32'd1);
    check("full_last_addr", 32'(mem_addr), 32'd511);
    idle();
    check("full_we_count", 32'(we_count - we_base), 32'd512);
    check("full_words", 32'(words_loaded), 32'd512);
    check("full_cpu_run", 32'(cpu_run), 32'd1);
    bad = 0;
    for (int w = 0; w < 512; w++) if (mem[w] !== pw(w)) bad++;
    check("full_data", 32'(bad), 32'd0);
    check("full_mem0", mem[0], 32'h0047_8ED5);

    // Reset in the middle of a load, then a fresh one-word frame.
    pulse_restart();
    send(8'h00); send(8'h03);
    for (int k = 0; k < 6; k++) send(8'h50 + 8'(k));
    reset = 1'b1;
    #2;
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_words", 32'(words_loaded), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    send(8'h00); send(8'h01);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    check("mid_addr", 32'(mem_addr), 32'd0);
    idle();
    check("mid_mem0", mem[0], 32'hDEAD_BEEF);
    check("mid_cpu_run", 32'(cpu_run), 32'd1);
    check("mid_words", 32'(words_loaded), 32'd1);

    // in_valid toggling during DATA.
    pulse_restart();
    send(8'h00); send(8'h02);
    for (int k = 0; k < 8; k++) begin
      send(8'h10 + 8'(k));
      check("tog_we", 32'(mem_we), (k % 4 == 3) ? 32'd1 : 32'd0);
      idle();
      check("tog_idle_we", 32'(mem_we), 32'd0);
    end
    check("tog_mem0", mem[0], 32'h1011_1213);
    check("tog_mem1", mem[1], 32'h1415_1617);
    check("tog_cpu_run", 32'(cpu_run), 32'd1);
    check("tog_words", 32'(words_loaded), 32'd2);

`ifdef LOADER_CHECKSUM_EN
    pulse_restart();
    send(8'h00); send(8'h01);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    check("ck_pending_run", 32'(cpu_run), 32'd0);
    send(8'h44);
    check("ck_ok_run", 32'(cpu_run), 32'd1);
    check("ck_ok_err", 32'(load_err), 32'd0);
    pulse_restart();
    send(8'h00); send(8'h01);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h45);
    check("ck_bad_err", 32'(load_err), 32'd1);
    check("ck_bad_run", 32'(cpu_run), 32'd0);
    check("ck_bad_mem", mem[0], 32'h1122_3344);
    pulse_restart();
    check("ck_rs_err", 32'(load_err), 32'd0);
    check("ck_rs_ready", 32'(in_ready), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
